// File: rtl/smc_pkg.sv
// Shared definitions for the SCCB init sequencer: register map, control-byte layout,
// table markers and sequencer states.
package smc_pkg;

  // Register offsets relative to the SCCB master controller base address
  localparam logic [7:0] REG_CONF_SLV = 8'h00;
  localparam logic [7:0] REG_CONF_PRE = 8'h01;
  localparam logic [7:0] REG_TX_CTL   = 8'h10;
  localparam logic [7:0] REG_TX_SUB   = 8'h11;
  localparam logic [7:0] REG_TX_DAT   = 8'h12;
  localparam logic [7:0] REG_RX_DAT   = 8'h20;

  // Control-byte field positions and values
  localparam int unsigned CTL_TRANS_BIT = 0;
  localparam int unsigned CTL_PHASE_LSB = 1;
  localparam int unsigned CTL_PHASE_W   = 2;
  localparam logic        CTL_TRANS_WR  = 1'b0;
  localparam logic [1:0]  CTL_PHASE_3   = 2'd3;

  // Table markers
  localparam logic [15:0] TBL_END       = 16'hFFFF;
  localparam logic [7:0]  TBL_DELAY_PFX = 8'hFE;

  // AXI constants
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // One configuration-table word
  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] data;
  } tbl_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_SLV,
    ST_W_PRE,
    ST_FETCH,
    ST_DECODE,
    ST_W_SUB,
    ST_W_DAT,
    ST_W_CTL,
    ST_DELAY,
    ST_FIN
  } smc_state_e;

  // Assemble the control byte from its fields
  function automatic logic [7:0] ctl_byte(input logic trans_type, input logic [1:0] phase_amt);
    logic [7:0] b;
    b = '0;
    b[CTL_TRANS_BIT] = trans_type;
    b[CTL_PHASE_LSB +: CTL_PHASE_W] = phase_amt;
    return b;
  endfunction

endpackage

// File: rtl/smc_axi_wr_single.sv
// One-beat AXI4 write master: launches AW and W together, retires each on its own
// handshake, then accepts the B response.
module smc_axi_wr_single
  import smc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_c,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              done_c,
  output logic [RESP_W-1:0] resp_c,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [RESP_W-1:0] m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o
);

  logic active;
  logic aw_clear;
  logic w_clear;

  // A write is in flight from launch until the B handshake
  assign active   = m_awvalid_o || m_wvalid_o || m_bready_o;
  assign aw_clear = !m_awvalid_o || m_awready_i;
  assign w_clear  = !m_wvalid_o || m_wready_i;
  assign done_c   = m_bready_o && m_bvalid_i;
  assign resp_c   = m_bresp_i;

  // Launch on request, drop each valid after its handshake, open B once both beats are gone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      m_awaddr_o  <= '0;
      m_wdata_o   <= '0;
    end else if (req_c && !active) begin
      m_awvalid_o <= 1'b1;
      m_wvalid_o  <= 1'b1;
      m_awaddr_o  <= addr;
      m_wdata_o   <= data;
    end else begin
      if (m_awvalid_o && m_awready_i) m_awvalid_o <= 1'b0;
      if (m_wvalid_o && m_wready_i)   m_wvalid_o  <= 1'b0;
      if (done_c) begin
        m_bready_o <= 1'b0;
      end else if (active && !m_bready_o && aw_clear && w_clear) begin
        m_bready_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a {sub_addr, data} table and turns each entry into register writes on the
// SCCB master controller, after programming slave address and prescaler.
module sccb_init_sequencer
  import smc_pkg::*;
#(
  parameter logic [31:0] SMC_BASE_ADDR = 32'h2000_0000,
  parameter int unsigned ATX_DATA_W    = 8,
  parameter int unsigned ATX_ADDR_W    = 32,
  parameter int unsigned ATX_ID_W      = 5,
  parameter int unsigned ATX_LEN_W     = 8,
  parameter int unsigned ATX_RESP_W    = 2,
  parameter logic [6:0]  SLV_DVC_ADDR  = 7'h21,
  parameter logic [7:0]  PRESCALER     = 8'd4,
  parameter int unsigned TBL_ADDR_W    = 8,
  parameter int unsigned DELAY_UNIT    = 125_000,
  parameter int unsigned AXI_ID        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [TBL_ADDR_W-1:0] tbl_addr_o,
  input  logic [15:0]           tbl_data_i,
  output logic [ATX_ID_W-1:0]   m_awid_o,
  output logic [ATX_ADDR_W-1:0] m_awaddr_o,
  output logic [1:0]            m_awburst_o,
  output logic [ATX_LEN_W-1:0]  m_awlen_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [ATX_DATA_W-1:0] m_wdata_o,
  output logic                  m_wlast_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [ATX_ID_W-1:0]   m_bid_i,
  input  logic [ATX_RESP_W-1:0] m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o
);

  localparam int unsigned DLY_W = 32;

  smc_state_e            state, state_nx;
  tbl_entry_t            tbl_word;
  tbl_entry_t            entry_q, entry_d;
  logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
  logic                  busy_d, done_d, err_d;
  logic [TBL_ADDR_W-1:0] tbl_addr_d;
  logic                  last_entry;

  logic                  wr_req_c;
  logic [7:0]            wr_ofs_c;
  logic [7:0]            wr_data_c;
  logic [ATX_ADDR_W-1:0] wr_addr_c;
  logic                  wr_done_c;
  logic [ATX_RESP_W-1:0] wr_resp_c;
  logic                  wr_ok_c;
  logic                  wr_fail_c;
  logic                  unused_bid;

  assign m_awid_o    = ATX_ID_W'(AXI_ID);
  assign m_awburst_o = BURST_INCR;
  assign m_awlen_o   = '0;
  assign m_wlast_o   = 1'b1;
  assign unused_bid  = ^m_bid_i;

  assign tbl_word   = tbl_data_i;
  assign last_entry = &tbl_addr_o;
  assign wr_addr_c  = ATX_ADDR_W'(SMC_BASE_ADDR) + ATX_ADDR_W'(wr_ofs_c);
  assign wr_ok_c    = wr_done_c && (wr_resp_c == ATX_RESP_W'(RESP_OKAY));
  assign wr_fail_c  = wr_done_c && (wr_resp_c != ATX_RESP_W'(RESP_OKAY));

  smc_axi_wr_single #(
    .ADDR_W (ATX_ADDR_W),
    .DATA_W (ATX_DATA_W),
    .RESP_W (ATX_RESP_W)
  ) u_wr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_c       (wr_req_c),
    .addr        (wr_addr_c),
    .data        (ATX_DATA_W'(wr_data_c)),
    .done_c      (wr_done_c),
    .resp_c      (wr_resp_c),
    .m_awaddr_o  (m_awaddr_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awready_i (m_awready_i),
    .m_wdata_o   (m_wdata_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wready_i  (m_wready_i),
    .m_bresp_i   (m_bresp_i),
    .m_bvalid_i  (m_bvalid_i),
    .m_bready_o  (m_bready_o)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      tbl_addr_o <= '0;
      entry_q    <= '0;
      dly_cnt_q  <= '0;
    end else begin
      state      <= state_nx;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
      tbl_addr_o <= tbl_addr_d;
      entry_q    <= entry_d;
      dly_cnt_q  <= dly_cnt_d;
    end
  end

  // Next-state selection; any error response short-circuits to FIN
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (start_i) state_nx = ST_W_SLV;
      ST_W_SLV:  if (wr_fail_c) state_nx = ST_FIN; else if (wr_ok_c) state_nx = ST_W_PRE;
      ST_W_PRE:  if (wr_fail_c) state_nx = ST_FIN; else if (wr_ok_c) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: begin
        if (tbl_data_i == TBL_END)                  state_nx = ST_FIN;
        else if (tbl_word.sub_addr == TBL_DELAY_PFX) state_nx = ST_DELAY;
        else                                         state_nx = ST_W_SUB;
      end
      ST_W_SUB:  if (wr_fail_c) state_nx = ST_FIN; else if (wr_ok_c) state_nx = ST_W_DAT;
      ST_W_DAT:  if (wr_fail_c) state_nx = ST_FIN; else if (wr_ok_c) state_nx = ST_W_CTL;
      ST_W_CTL: begin
        if (wr_fail_c)   state_nx = ST_FIN;
        else if (wr_ok_c) state_nx = last_entry ? ST_FIN : ST_FETCH;
      end
      ST_DELAY:  if (dly_cnt_q == '0) state_nx = last_entry ? ST_FIN : ST_FETCH;
      ST_FIN:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Register next-values and write-request generation
  always_comb begin
    busy_d     = busy_o;
    done_d     = 1'b0;
    err_d      = err_o;
    tbl_addr_d = tbl_addr_o;
    entry_d    = entry_q;
    dly_cnt_d  = dly_cnt_q;
    wr_req_c   = 1'b0;
    wr_ofs_c   = REG_CONF_SLV;
    wr_data_c  = '0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          tbl_addr_d = '0;
        end
      end
      ST_W_SLV: begin
        wr_req_c  = 1'b1;
        wr_ofs_c  = REG_CONF_SLV;
        wr_data_c = {1'b0, SLV_DVC_ADDR};
      end
      ST_W_PRE: begin
        wr_req_c  = 1'b1;
        wr_ofs_c  = REG_CONF_PRE;
        wr_data_c = PRESCALER;
      end
      ST_DECODE: begin
        entry_d   = tbl_word;
        dly_cnt_d = DLY_W'(tbl_word.data) * DLY_W'(DELAY_UNIT);
      end
      ST_W_SUB: begin
        wr_req_c  = 1'b1;
        wr_ofs_c  = REG_TX_SUB;
        wr_data_c = entry_q.sub_addr;
      end
      ST_W_DAT: begin
        wr_req_c  = 1'b1;
        wr_ofs_c  = REG_TX_DAT;
        wr_data_c = entry_q.data;
      end
      ST_W_CTL: begin
        wr_req_c  = 1'b1;
        wr_ofs_c  = REG_TX_CTL;
        wr_data_c = ctl_byte(CTL_TRANS_WR, CTL_PHASE_3);
        if (wr_ok_c && !last_entry) tbl_addr_d = tbl_addr_o + TBL_ADDR_W'(1);
      end
      ST_DELAY: begin
        if (dly_cnt_q != '0)  dly_cnt_d  = dly_cnt_q - DLY_W'(1);
        else if (!last_entry) tbl_addr_d = tbl_addr_o + TBL_ADDR_W'(1);
      end
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    if (wr_fail_c) err_d = 1'b1;
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Upstream AXI4 write master that drives the SCCB master controller's register map.
- On start_i, programs the slave device address and prescaler, then walks a table of {sub_addr, data} entries.
- Each table entry becomes one SCCB 3-phase write.
- Used for camera-sensor power-up configuration with no CPU involvement. Supports end markers, delay entries and error abort.

Parameters:
- SMC_BASE_ADDR, 32'h2000_0000, AXI base address of the SCCB master controller.
- ATX_DATA_W, 8, AXI data width (fixed at 8).
- ATX_ADDR_W, 32, AXI address width.
- ATX_ID_W, 5, AXI ID width.
- ATX_LEN_W, 8, AXI len width.
- ATX_RESP_W, 2, AXI resp width.
- SLV_DVC_ADDR, 7'h21, 7-bit SCCB slave device address.
- PRESCALER, 8'd4, prescaler value to program.
- TBL_ADDR_W, 8, table address width (maximum 2^TBL_ADDR_W entries).
- DELAY_UNIT, 125_000, clock cycles per delay unit (1 ms at 125 MHz).
- AXI_ID, 0, constant AWID used for all writes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  pulse that starts a sequence; ignored while busy_o=1.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at sequence end.
- err_o  out  1  sticky flag: a non-OKAY BRESP was received; cleared by start_i.
- tbl_addr_o  out  TBL_ADDR_W  table read address.
- tbl_data_i  in  16  table word {sub_addr[15:8], data[7:0]}; 1-cycle synchronous read latency.
- m_awid_o  out  ATX_ID_W  write address ID.
- m_awaddr_o  out  ATX_ADDR_W  write address.
- m_awburst_o  out  2  burst type, constant 2'b01 (INCR).
- m_awlen_o  out  ATX_LEN_W  burst length, constant 0.
- m_awvalid_o  out  1  AW valid.
- m_awready_i  in  1  AW ready.
- m_wdata_o  out  ATX_DATA_W  write data.
- m_wlast_o  out  1  W last, constant 1.
- m_wvalid_o  out  1  W valid.
- m_wready_i  in  1  W ready.
- m_bid_i  in  ATX_ID_W  B ID; ignored.
- m_bresp_i  in  ATX_RESP_W  B response.
- m_bvalid_i  in  1  B valid.
- m_bready_o  out  1  B ready.

Behaviour:
- Reset:
  - All valid outputs, busy_o, done_o, err_o are 0.
  - tbl_addr_o is 0; FSM is in IDLE.
  - Reset mid-transfer drops all valids immediately; no transfer is resumed.
- Register offsets from SMC_BASE_ADDR:
  - 0x00 slave address, written as {1'b0, SLV_DVC_ADDR}.
  - 0x01 prescaler.
  - 0x10 control byte: [0] trans_type (0 = write), [2:1] phase_amt (2'd3).
  - 0x11 sub-address.
  - 0x12 tx data.
- Single write (sub-module):
  - AW and W are asserted in the same cycle with fixed address and data.
  - Each valid drops independently after its own handshake.
  - m_bready_o=1 once both AW and W have completed.
  - The write completes on the B handshake. Minimum is 2 cycles if ready is already high.
- FSM states: IDLE, W_SLV, W_PRE, FETCH, DECODE, W_SUB, W_DAT, W_CTL, DELAY, FIN.
  - IDLE: on start_i, go to W_SLV; tbl_addr_o=0, err_o=0, busy_o=1.
  - W_SLV then W_PRE.
  - FETCH: one wait cycle for the table read.
  - DECODE, by entry value:
    - 16'hFFFF: go to FIN.
    - {8'hFE, N}: go to DELAY for N*DELAY_UNIT cycles; N=0 means zero delay.
    - Otherwise: W_SUB, then W_DAT, then W_CTL. Data FIFOs are written before control so the controller never sees control without operands.
  - After W_CTL or DELAY:
    - If tbl_addr_o is all-ones (last entry), go to FIN; the address does not wrap.
    - Otherwise increment tbl_addr_o and go to FETCH.
  - FIN: pulse done_o for 1 cycle, clear busy_o, return to IDLE.
- Any BRESP != 2'b00: set err_o, skip the remaining writes, go to FIN.
- AXI back-pressure (controller FIFO full) only stalls the sequencer; it never drops a write. There is no timeout.
- start_i together with reset: reset wins.

Decomposition:
- Shared package smc_pkg holds:
  - Register offsets: CONF 0x00/0x01; TX 0x10/0x11/0x12; RX 0x20.
  - Control-byte field positions.
  - Table marker constants: END 16'hFFFF, DELAY prefix 8'hFE.
  - FSM state enum.
- Sub-module smc_axi_wr_single: a one-beat AW/W/B master with req/addr/data in and done/resp out.

Test Plan:
- Table {0x1280, 0x1101, 0xFFFF}, all ready=1 → writes in order:
  - 0x00 ← 0x21, 0x01 ← 0x04.
  - 0x11 ← 0x12, 0x12 ← 0x80, 0x10 ← 0x06.
  - 0x11 ← 0x11, 0x12 ← 0x01, 0x10 ← 0x06.
  - Then a done_o pulse; err_o=0.
- m_wready_i held 0 for 10 cycles, with AW accepted first → m_awvalid_o drops after its handshake, m_wvalid_o is held with stable data, and m_bready_o rises only after W completes.
- Table {0xFE03, 0xFFFF} with DELAY_UNIT=4 → no write after W_PRE; done_o follows after ≥12 idle cycles.
- BRESP=2'b10 on the second entry's W_DAT → W_CTL is not issued, err_o=1, done_o pulses; the next start_i clears err_o.
- Table with no end marker and TBL_ADDR_W=2 → exactly 4 entries issued, then done_o; tbl_addr_o stays at 3.
- rst_n=0 during W_SUB → next cycle all valids=0, busy_o=0; start_i afterwards restarts from W_SLV.
